// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by the data-memory responder and the
// control-unit decode: load/store opcodes, funct3 access-size codes and the
// responder FSM state type.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for loads and stores.
//  we_i      : 1 = store, 0 = load
//  funct3_i  : access size/sign code
//  lane_i    : byte address bits [1:0]
//  wdata_i   : right-aligned store data
//  rword_i   : current contents of the addressed word
//  be_o      : per-byte write enables (all zero on loads or faults)
//  wdata_o   : store data replicated onto every lane it may target
//  rdata_o   : selected load lane(s), sign/zero extended (zero on faults)
//  fault_o   : misaligned access or illegal funct3 for this direction
module lsu_lane_align
  import riscv_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        fault_o
);

  logic [31:0] rsh;
  logic [3:0]  be_raw;
  logic [31:0] ld_raw;
  logic        misalign;
  logic        illegal;

  // Shift the addressed lane down to bit 0 so extension is lane independent.
  assign rsh = rword_i >> {lane_i, 3'b000};

  always_comb begin
    be_raw   = 4'b0000;
    wdata_o  = 32'h0;
    ld_raw   = 32'h0;
    misalign = 1'b0;
    illegal  = 1'b0;
    case (funct3_i)
      F3_B, F3_BU: begin
        be_raw  = 4'b0001 << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
        ld_raw  = (funct3_i == F3_B) ? {{24{rsh[7]}}, rsh[7:0]} : {24'h0, rsh[7:0]};
      end
      F3_H, F3_HU: begin
        misalign = lane_i[0];
        be_raw   = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o  = {2{wdata_i[15:0]}};
        ld_raw   = (funct3_i == F3_H) ? {{16{rsh[15]}}, rsh[15:0]} : {16'h0, rsh[15:0]};
      end
      F3_W: begin
        misalign = (lane_i != 2'b00);
        be_raw   = 4'b1111;
        wdata_o  = wdata_i;
        ld_raw   = rword_i;
      end
      default: illegal = 1'b1;
    endcase
    // Unsigned variants exist only for loads.
    if (we_i && ((funct3_i == F3_BU) || (funct3_i == F3_HU))) begin
      illegal = 1'b1;
    end
  end

  assign fault_o = misalign | illegal;
  assign be_o    = (we_i && !fault_o) ? be_raw : 4'b0000;
  assign rdata_o = (!we_i && !fault_o) ? ld_raw : 32'h0;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for core load/store requests.
//  clk, rst_n            : clock, asynchronous active-low reset
//  req_valid / req_ready : request handshake; a request is accepted on a rising
//                          edge where both are 1. req_ready is 1 only in IDLE,
//                          and a held req_valid while not ready has no effect.
//  req_we, req_funct3    : store flag and access size/sign
//  req_addr, req_wdata   : byte address and right-aligned store data
//  rsp_valid             : one-cycle pulse WAIT_STATES+1 edges after acceptance
//  rsp_rdata, rsp_err    : load result / fault flag, zero outside the pulse
//  dbg_state             : current FSM state for observation
module data_mem_responder
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output dmem_state_t dbg_state
);

  localparam int unsigned IW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  dmem_state_t state_q;
  logic [3:0]  cnt_q;
  logic [31:0] cap_rdata_q;
  logic        cap_err_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [IW-1:0] idx;
  logic          in_range;
  logic [31:0]   rword;
  logic [3:0]    be;
  logic [31:0]   wdata_sh;
  logic [31:0]   ld_data;
  logic          align_fault;
  logic          accept;
  logic          acc_err;
  logic [31:0]   acc_rdata;

  assign idx      = req_addr[IW+1:2];
  assign in_range = (req_addr[31:2] < 30'(DEPTH_WORDS));
  // Out-of-range indices never reach the array read.
  assign rword    = in_range ? mem[idx] : 32'h0;

  lsu_lane_align u_align (
    .we_i     (req_we),
    .funct3_i (req_funct3),
    .lane_i   (req_addr[1:0]),
    .wdata_i  (req_wdata),
    .rword_i  (rword),
    .be_o     (be),
    .wdata_o  (wdata_sh),
    .rdata_o  (ld_data),
    .fault_o  (align_fault)
  );

  assign req_ready = (state_q == IDLE);
  // Nothing is accepted while reset is asserted.
  assign accept    = req_valid && req_ready && rst_n;
  assign acc_err   = align_fault || !in_range;
  assign acc_rdata = acc_err ? 32'h0 : ld_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      cap_rdata_q <= 32'h0;
      cap_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            cap_rdata_q <= acc_rdata;
            cap_err_q   <= acc_err;
            cnt_q       <= 4'd0;
            if (WAIT_STATES == 0) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= acc_rdata;
              rsp_err_q   <= acc_err;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'(WAIT_STATES - 1)) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= cap_rdata_q;
            rsp_err_q   <= cap_err_q;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array contents survive reset; a store commits on its acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  import riscv_pkg::*;

  localparam int DEPTH = 1024;
  localparam int WS    = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  dmem_state_t dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference byte storage for the low 256 bytes (the only in-range area used).
  logic [7:0] mb [256];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [16];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: decide fault from the access rules, then read or
  // update the byte array with plain little-endian arithmetic.
  function automatic void model_op(input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   output logic [31:0] rd, output logic er);
    int size;
    bit legal, sgn;
    logic [31:0] v;
    legal = we ? (f3 inside {3'b000, 3'b001, 3'b010})
               : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    sgn   = (f3[2] == 1'b0);
    er    = !legal || ((addr % size) != 0) || ((addr / 4) >= DEPTH);
    rd    = 32'h0;
    if (er) return;
    if (we) begin
      for (int i = 0; i < size; i++) mb[addr[7:0] + i] = wdata[i*8 +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(mb[addr[7:0] + i]) << (8 * i));
      if (sgn && size < 4 && v[8*size-1]) v = v | ~((32'h1 << (8 * size)) - 1);
      rd = v;
    end
  endfunction

  // One handshake plus response collection; checks latency, ready behaviour
  // and that response fields stay zero outside the pulse.
  task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rd, output logic er);
    int n;
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL ready_timeout: req_ready stuck at 0, expected 1");
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr = $urandom;
    req_wdata = $urandom;
    chk("ready_busy", 32'(req_ready), 32'd0);
    lat = 0;
    rd = 32'h0;
    er = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        rd = rsp_rdata;
        er = rsp_err;
        break;
      end
      chk("idle_rsp_fields", {rsp_err, rsp_rdata[30:0]} | {31'h0, rsp_rdata[31]}, 32'h0);
    end
    chk("latency", 32'(lat), 32'(WS + 1));
    @(negedge clk);
    chk("pulse_one_cycle", 32'(rsp_valid), 32'd0);
  endtask

  task automatic run_vec(input int i);
    logic [31:0] rd, mrd;
    logic er, mer;
    xfer(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, er);
    model_op(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, mrd, mer);
    chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
    chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
  endtask

  task automatic run_model(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    logic [31:0] rd, mrd;
    logic er, mer;
    model_op(we, f3, addr, wdata, mrd, mer);
    xfer(we, f3, addr, wdata, rd, er);
    chk({tag, "_rdata"}, rd, mrd);
    chk({tag, "_err"}, 32'(er), 32'(mer));
  endtask

  initial begin
    int acc, rsps, both, busy_rdy, n;
    logic [31:0] mrd, a;
    logic mer, we;
    logic [2:0] f3;

    tbl[0]  = '{1'b1, F3_W,   32'h10,        32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, F3_W,   32'h10,        32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, F3_B,   32'h13,        32'h0,        32'hFFFFFFDE, 1'b0};
    tbl[3]  = '{1'b0, F3_BU,  32'h13,        32'h0,        32'h000000DE, 1'b0};
    tbl[4]  = '{1'b0, F3_H,   32'h10,        32'h0,        32'hFFFFBEEF, 1'b0};
    tbl[5]  = '{1'b0, F3_HU,  32'h12,        32'h0,        32'h0000DEAD, 1'b0};
    tbl[6]  = '{1'b1, F3_B,   32'h11,        32'hFFFFFF55, 32'h0,        1'b0};
    tbl[7]  = '{1'b0, F3_W,   32'h10,        32'h0,        32'hDEAD55EF, 1'b0};
    tbl[8]  = '{1'b1, F3_H,   32'h12,        32'hABCD1234, 32'h0,        1'b0};
    tbl[9]  = '{1'b0, F3_W,   32'h10,        32'h0,        32'h123455EF, 1'b0};
    tbl[10] = '{1'b0, F3_W,   32'h12,        32'h0,        32'h0,        1'b1};
    tbl[11] = '{1'b1, F3_H,   32'h11,        32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[12] = '{1'b0, 3'b011, 32'h10,        32'h0,        32'h0,        1'b1};
    tbl[13] = '{1'b0, F3_W,   32'(4*DEPTH),  32'h0,        32'h0,        1'b1};
    tbl[14] = '{1'b1, F3_BU,  32'h10,        32'h00000077, 32'h0,        1'b1};
    tbl[15] = '{1'b0, F3_W,   32'h10,        32'h0,        32'h123455EF, 1'b0};

    // Reset held for 3 cycles.
    repeat (3) begin
      @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    for (int i = 0; i < 16; i++) run_vec(i);

    // Back-to-back: req_valid held high for three loads.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h10;
    acc = 0; rsps = 0; both = 0; busy_rdy = 0;
    for (int c = 0; c < 30; c++) begin
      if (acc >= 3) req_valid = 1'b0;
      if (req_valid && req_ready) acc++;
      if (rsp_valid) begin
        rsps++;
        chk("b2b_rdata", rsp_rdata, 32'h123455EF);
      end
      if (req_ready && rsp_valid) both++;
      if (dbg_state != IDLE && req_ready) busy_rdy++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd3);
    chk("b2b_responses", 32'(rsps), 32'd3);
    chk("b2b_ready_in_resp", 32'(both), 32'd0);
    chk("b2b_ready_when_busy", 32'(busy_rdy), 32'd0);

    // Reset during WAIT: response dropped, store kept.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("midrst_in_wait", 32'(dbg_state), 32'(WAIT));
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsps = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) rsps++;
    end
    chk("midrst_no_rsp", 32'(rsps), 32'd0);
    model_op(1'b1, F3_W, 32'h20, 32'hCAFEF00D, mrd, mer);
    run_model(1'b0, F3_W, 32'h20, 32'h0, "midrst_readback");

    // Fill the modelled window, then random traffic against the model.
    for (int w = 0; w < 64; w++) run_model(1'b1, F3_W, 32'(4 * w), $urandom, "init");
    for (int r = 0; r < 250; r++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) a = 32'(4 * DEPTH) + $urandom_range(0, 100000);
      else a = 32'($urandom_range(0, 255));
      run_model(we, f3, a, $urandom, $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
